// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for the 1-bit ALU slice.
// Feeds operands LSB-first, chains carry, assembles the result word.
module alu_serial_seq #(
  parameter  int WIDTH = 128,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic [2:0]       in_opsel,
  input  logic             in_cin,
  output logic             s_op1,
  output logic             s_op2,
  output logic             s_mode,
  output logic [2:0]       s_opsel,
  output logic             s_cin,
  input  logic             s_result,
  input  logic             s_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             mode_reg;
  logic [2:0]       opsel_reg;
  logic             carry;
  logic [CNT_W-1:0] idx;

  logic             run;
  logic             last;
  logic [WIDTH-1:0] res_bit;
  logic [WIDTH-1:0] res_next;

  assign run  = (state == RUN);
  assign last = (idx == CNT_W'(WIDTH - 1));

  // res_reg is cleared on accept, so OR-ing the new bit in is enough
  always_comb begin
    res_bit  = '0;
    res_bit  = {{(WIDTH-1){1'b0}}, s_result} << idx;
    res_next = res_reg | res_bit;
  end

  // slice drive is forced low outside RUN
  always_comb begin
    s_op1   = 1'b0;
    s_op2   = 1'b0;
    s_mode  = 1'b0;
    s_opsel = 3'b000;
    s_cin   = 1'b0;
    if (run) begin
      s_op1   = a_reg[idx];
      s_op2   = b_reg[idx];
      s_mode  = mode_reg;
      s_opsel = opsel_reg;
      s_cin   = carry;
    end
  end

  // sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      mode_reg   <= 1'b0;
      opsel_reg  <= 3'b000;
      carry      <= 1'b0;
      idx        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
      out_zero   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            mode_reg  <= in_mode;
            opsel_reg <= in_opsel;
            carry     <= in_cin;
            idx       <= '0;
            res_reg   <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_reg <= res_next;
          carry   <= s_cout;
          if (last) begin
            out_result <= res_next;
            out_cout   <= s_cout;
            out_zero   <= ~|res_next;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq at WIDTH=8 with a full-add slice model.
// Expected words are queued at issue and checked by a monitor.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_mode;
  logic [2:0]   in_opsel;
  logic         in_cin;
  logic         s_op1;
  logic         s_op2;
  logic         s_mode;
  logic [2:0]   s_opsel;
  logic         s_cin;
  logic         s_result;
  logic         s_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_zero;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  time  t_acc;
  time  t_hs;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_opsel   (in_opsel),
    .in_cin     (in_cin),
    .s_op1      (s_op1),
    .s_op2      (s_op2),
    .s_mode     (s_mode),
    .s_opsel    (s_opsel),
    .s_cin      (s_cin),
    .s_result   (s_result),
    .s_cout     (s_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero)
  );

  // slice model: mode=1 opsel=000 is a full adder, anything else is AND
  logic is_add;
  assign is_add   = s_mode && (s_opsel == 3'b000);
  assign s_result = is_add ? (s_op1 ^ s_op2 ^ s_cin) : (s_op1 & s_op2);
  assign s_cout   = is_add ?
    ((s_op1 & s_op2) | (s_op1 & s_cin) | (s_op2 & s_cin)) : 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare every result handshake against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        t_hs = $time;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_result", 32'(out_result), 32'(e.r));
          chk("out_cout", 32'(out_cout), 32'(e.c));
          chk("out_zero", 32'(out_zero), 32'(e.z));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [W-1:0] er,
                      input logic ec);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_mode  = 1'b1;
    in_opsel = 3'b000;
    e.r = er;
    e.c = ec;
    e.z = (er == '0);
    exp_q.push_back(e);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 60);
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    in_opsel  = 3'b000;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_cout", 32'(out_cout), 0);
    chk("rst_out_zero", 32'(out_zero), 1);
    chk("rst_s_bus", 32'({s_op1, s_op2, s_mode, s_opsel, s_cin}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: add, latency counted in edges including the accept edge
    send(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    n = 1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    chk("latency_edges", 32'(n), 9);
    wait_idle();

    // 2: carry out and zero flag
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    wait_valid();
    wait_idle();

    // 3: carry-in feeds bit 0 only
    send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk($sformatf("s_cin_idx%0d", i), 32'(s_cin), (i == 0) ? 1 : 0);
    end
    wait_valid();
    chk("s_cin_done", 32'(s_cin), 0);
    wait_idle();

    // 4: backpressure holds DONE and ignores new operands
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      in_a     = 8'hAA;
      in_b     = 8'h55;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_result", 32'(out_result), 32'h46);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // 5: reset in the middle of an operation
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_idx4_op1", 32'(s_op1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_zero", 32'(out_zero), 1);
    chk("mid_rst_s_op1", 32'(s_op1), 0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    wait_valid();
    wait_idle();

    // 6: back-to-back with out_ready tied high
    out_ready = 1'b1;
    send(8'h70, 8'h0F, 1'b0, 8'h7F, 1'b0);
    send(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);
    chk("b2b_gap", 32'(t_acc - (t_hs + 5)), 10);
    wait_valid();
    wait_idle();

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
